// File: rtl/pianissimo_top.sv
// Pianissimo piano top: PS/2 receiver and scan-code decoder track eight held keys,
// and a drawing FSM plots a 160x120 keyboard one pixel per clock.
module pianissimo_top (
    input  logic        CLOCK_50,
    output logic [23:0] VGA_COLOR,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic        plot,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic [3:0]  KEY
);
    localparam logic [15:0] TMO_LAST = 16'd49999;

    typedef enum logic [1:0] {ST_FULL = 2'd0, ST_IDLE = 2'd1, ST_KEY = 2'd2} state_t;

    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Returns {hit, key index} for the eight piano scan codes.
    function automatic logic [3:0] key_lookup(input logic [7:0] code);
        case (code)
            8'h1C:   key_lookup = 4'b1000;
            8'h1B:   key_lookup = 4'b1001;
            8'h23:   key_lookup = 4'b1010;
            8'h2B:   key_lookup = 4'b1011;
            8'h34:   key_lookup = 4'b1100;
            8'h33:   key_lookup = 4'b1101;
            8'h3B:   key_lookup = 4'b1110;
            8'h42:   key_lookup = 4'b1111;
            default: key_lookup = 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

    function automatic logic [23:0] pixel_color(input logic [6:0] y, input logic [4:0] off,
                                                input logic held);
        if (y < 7'd40 || off == 5'd0) return 24'h000000;
        else if (held)                return 24'h00C0FF;
        else                          return 24'hFFFFFF;
    endfunction

    logic        rst_n;
    logic        unused_keys_s;
    assign rst_n         = KEY[0];
    assign unused_keys_s = ^KEY[3:1];

    logic        clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic        fall_s;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shift_q, shift_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_vld_q, byte_vld_d;
    logic [10:0] frame_s;
    logic [7:0]  pressed_q, pressed_d;
    logic        brk_q, brk_d, ext_q, ext_d;
    logic [3:0]  lookup_s;

    assign fall_s   = clk_prev_q & ~clk_s2_q;
    assign lookup_s = key_lookup(byte_q);

    // Frame assembly: bits shift in LSB-first; the 11th edge validates and emits the byte.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        frame_s    = {dat_s2_q, shift_q};
        if (fall_s) begin
            tmo_d = 16'd0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_s[0] && frame_s[10] && odd_parity_ok(frame_s[9:1])) begin
                    byte_vld_d = 1'b1;
                    byte_d     = frame_s[8:1];
                end else begin
                    byte_vld_d = 1'b0;
                end
            end else begin
                shift_d   = {dat_s2_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TMO_LAST) begin
                bit_cnt_d = 4'd0;
                tmo_d     = 16'd0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = 16'd0;
        end
    end

    // Scan-code decoder: prefixes arm flags, any other byte consumes them.
    always_comb begin
        pressed_d = pressed_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        if (byte_vld_q) begin
            case (byte_q)
                8'hF0: brk_d = 1'b1;
                8'hE0: ext_d = 1'b1;
                default: begin
                    if (lookup_s[3] && !ext_q) pressed_d[lookup_s[2:0]] = ~brk_q;
                    else                       pressed_d = pressed_q;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end else begin
            pressed_d = pressed_q;
        end
    end

    // Synchronisers, receiver and decoder state.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 10'd0;
            tmo_q      <= 16'd0;
            byte_q     <= 8'd0;
            byte_vld_q <= 1'b0;
            pressed_q  <= 8'd0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            pressed_q  <= pressed_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
        end
    end

    state_t      state_q, state_d;
    logic [7:0]  cnt_x_q, cnt_x_d;
    logic [6:0]  cnt_y_q, cnt_y_d;
    logic [4:0]  off_q, off_d;
    logic [2:0]  key_q, key_d;
    logic [7:0]  pending_q, pending_d, pend_clr_s;
    logic [2:0]  sel_s;
    logic [7:0]  sel_x_s;
    logic        plot_q, plot_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [23:0] color_q, color_d;
    logic [23:0] pix_color_s;

    assign sel_s       = lowest_set(pending_q);
    assign sel_x_s     = ({5'd0, sel_s} << 4) + ({5'd0, sel_s} << 2);
    assign pix_color_s = pixel_color(cnt_y_q, off_q, pressed_q[key_q]);

    // Drawing sequencer; off_q/key_q track x%20 and x/20 alongside cnt_x_q.
    always_comb begin
        state_d    = state_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        off_d      = off_q;
        key_d      = key_q;
        pend_clr_s = 8'd0;
        plot_d     = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        color_d    = color_q;
        case (state_q)
            ST_FULL: begin
                plot_d  = 1'b1;
                x_d     = cnt_x_q;
                y_d     = cnt_y_q;
                color_d = pix_color_s;
                if (cnt_x_q == 8'd159) begin
                    cnt_x_d = 8'd0;
                    off_d   = 5'd0;
                    key_d   = 3'd0;
                    if (cnt_y_q == 7'd119) begin
                        cnt_y_d = 7'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_y_d = cnt_y_q + 7'd1;
                    end
                end else begin
                    cnt_x_d = cnt_x_q + 8'd1;
                    if (off_q == 5'd19) begin
                        off_d = 5'd0;
                        key_d = key_q + 3'd1;
                    end else begin
                        off_d = off_q + 5'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (pending_q != 8'd0) begin
                    pend_clr_s[sel_s] = 1'b1;
                    key_d   = sel_s;
                    cnt_x_d = sel_x_s;
                    cnt_y_d = 7'd40;
                    off_d   = 5'd0;
                    state_d = ST_KEY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY: begin
                plot_d  = 1'b1;
                x_d     = cnt_x_q;
                y_d     = cnt_y_q;
                color_d = pix_color_s;
                if (off_q == 5'd19) begin
                    cnt_x_d = cnt_x_q - 8'd19;
                    off_d   = 5'd0;
                    if (cnt_y_q == 7'd119) state_d = ST_IDLE;
                    else                   cnt_y_d = cnt_y_q + 7'd1;
                end else begin
                    cnt_x_d = cnt_x_q + 8'd1;
                    off_d   = off_q + 5'd1;
                end
            end
            default: state_d = ST_FULL;
        endcase
        // A key change in the same cycle as its selection keeps it pending.
        pending_d = (pending_q & ~pend_clr_s) | (pressed_d ^ pressed_q);
    end

    // Drawing state and registered pixel outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FULL;
            cnt_x_q   <= 8'd0;
            cnt_y_q   <= 7'd0;
            off_q     <= 5'd0;
            key_q     <= 3'd0;
            pending_q <= 8'd0;
            plot_q    <= 1'b0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            color_q   <= 24'd0;
        end else begin
            state_q   <= state_d;
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
            off_q     <= off_d;
            key_q     <= key_d;
            pending_q <= pending_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
        end
    end

    assign plot      = plot_q;
    assign VGA_X     = x_q;
    assign VGA_Y     = y_q;
    assign VGA_COLOR = color_q;
endmodule

// File: tb/tb_pianissimo_top.sv
// Bench for pianissimo_top: PS/2 frames in, captured pixel passes compared
// against a key-state model and the c(x,y) colour rule.
module tb_pianissimo_top;
    logic        clk = 1'b0;
    logic [23:0] vga_color;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic        plot;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [3:0]  key;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  pressed_m;
    logic [7:0]  codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    logic [7:0]  other [4] = '{8'h15, 8'h4B, 8'h1D, 8'h24};
    logic [7:0]  cap_x [$];
    logic [6:0]  cap_y [$];
    logic [23:0] cap_c [$];

    always #5 clk = ~clk;

    pianissimo_top dut (
        .CLOCK_50 (clk),
        .VGA_COLOR(vga_color),
        .VGA_X    (vga_x),
        .VGA_Y    (vga_y),
        .plot     (plot),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .KEY      (key)
    );

    function automatic logic [23:0] exp_color(input int x, input int y);
        if (y < 40)          return 24'h000000;
        if (x % 20 == 0)     return 24'h000000;
        if (pressed_m[x/20]) return 24'h00C0FF;
        return 24'hFFFFFF;
    endfunction

    // Counts captured pixels deviating from a full pass (k<0) or a redraw of key k.
    function automatic int pass_errors(input int k, input int n);
        int errs = 0;
        int ex, ey;
        for (int i = 0; i < n; i++) begin
            if (k < 0) begin ex = i % 160;        ey = i / 160;      end
            else       begin ex = 20*k + i % 20;  ey = 40 + i / 20;  end
            if (cap_x[i] !== 8'(ex) || cap_y[i] !== 7'(ey) || cap_c[i] !== exp_color(ex, ey))
                errs++;
        end
        return errs;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_dat = f[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (10) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic capture_pass(input int bound, output int n);
        cap_x.delete(); cap_y.delete(); cap_c.delete();
        n = 0;
        for (int t = 0; t < bound && plot !== 1'b1; t++) @(negedge clk);
        while (plot === 1'b1 && n < 20000) begin
            cap_x.push_back(vga_x);
            cap_y.push_back(vga_y);
            cap_c.push_back(vga_color);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        key = 4'b1110; ps2_clk = 1'b1; ps2_dat = 1'b1;
        pressed_m = 8'd0;
        repeat (5) @(negedge clk);
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%0b want=0", plot); end
        checks++; if (vga_x !== 8'd0 || vga_y !== 7'd0) begin failures++; $display("FAIL reset_xy got=%0d,%0d want=0,0", vga_x, vga_y); end
        checks++; if (vga_color !== 24'd0) begin failures++; $display("FAIL reset_color got=%h want=000000", vga_color); end
    endtask

    // Releases reset and checks a complete FULL pass, optionally pressing a key meanwhile.
    task automatic test_full(input bit do_send, input logic [7:0] code, input int kidx);
        int n = 0;
        key = 4'b1111;
        fork
            begin
                @(negedge clk);
                checks++;
                if (plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
                    failures++; $display("FAIL full_first_pixel got=%0b@%0d,%0d want=1@0,0", plot, vga_x, vga_y);
                end
                capture_pass(1, n);
            end
            begin
                if (do_send) begin repeat (50) @(negedge clk); send_byte(code, 1'b0); end
            end
        join
        if (do_send) pressed_m[kidx] = 1'b1;
        checks++; if (n !== 19200) begin failures++; $display("FAIL full_count got=%0d want=19200", n); end
        checks++; if (pass_errors(-1, n) !== 0) begin failures++; $display("FAIL full_pixels got=%0d bad want=0", pass_errors(-1, n)); end
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL full_idle_plot got=%0b want=0", plot); end
        if (!do_send) begin
            checks++; if (cap_c[0] !== 24'h000000) begin failures++; $display("FAIL px_0_0 got=%h want=000000", cap_c[0]); end
            checks++; if (cap_c[60*160+25] !== 24'hFFFFFF) begin failures++; $display("FAIL px_25_60 got=%h want=FFFFFF", cap_c[60*160+25]); end
            checks++; if (cap_c[60*160+20] !== 24'h000000) begin failures++; $display("FAIL px_20_60 got=%h want=000000", cap_c[60*160+20]); end
            checks++; if (cap_c[119*160+159] !== 24'hFFFFFF) begin failures++; $display("FAIL px_159_119 got=%h want=FFFFFF", cap_c[119*160+159]); end
        end else begin
            checks++; if (cap_c[100*160+150] !== 24'h00C0FF) begin failures++; $display("FAIL px_150_100 got=%h want=00C0FF", cap_c[100*160+150]); end
        end
    endtask

    task automatic test_press();
        int n;
        fork
            send_byte(8'h1C, 1'b0);
            capture_pass(400, n);
        join
        pressed_m[0] = 1'b1;
        checks++; if (n !== 1600) begin failures++; $display("FAIL press_count got=%0d want=1600", n); end
        checks++; if (pass_errors(0, n) !== 0) begin failures++; $display("FAIL press_pixels got=%0d bad want=0", pass_errors(0, n)); end
        checks++; if (cap_c[205] !== 24'h00C0FF) begin failures++; $display("FAIL press_px_5_50 got=%h want=00C0FF", cap_c[205]); end
        checks++; if (cap_c[200] !== 24'h000000) begin failures++; $display("FAIL press_px_0_50 got=%h want=000000", cap_c[200]); end
    endtask

    task automatic test_release();
        int n;
        fork
            begin send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0); end
            capture_pass(700, n);
        join
        pressed_m[0] = 1'b0;
        checks++; if (n !== 1600) begin failures++; $display("FAIL release_count got=%0d want=1600", n); end
        checks++; if (pass_errors(0, n) !== 0) begin failures++; $display("FAIL release_pixels got=%0d bad want=0", pass_errors(0, n)); end
        checks++; if (cap_c[205] !== 24'hFFFFFF) begin failures++; $display("FAIL release_px_5_50 got=%h want=FFFFFF", cap_c[205]); end
    endtask

    task automatic test_discard();
        int n;
        fork
            send_byte(8'h1C, 1'b1);
            capture_pass(400, n);
        join
        checks++; if (n !== 0) begin failures++; $display("FAIL bad_parity_plots got=%0d want=0", n); end
        fork
            begin send_byte(8'hE0, 1'b0); send_byte(8'h1C, 1'b0); end
            capture_pass(700, n);
        join
        checks++; if (n !== 0) begin failures++; $display("FAIL extended_plots got=%0d want=0", n); end
        // key 0 must still be up: a plain make now has to redraw it
        fork
            send_byte(8'h1C, 1'b0);
            capture_pass(400, n);
        join
        pressed_m[0] = 1'b1;
        checks++; if (n !== 1600) begin failures++; $display("FAIL discard_then_press_count got=%0d want=1600", n); end
        checks++; if (pass_errors(0, n) !== 0) begin failures++; $display("FAIL discard_then_press_pixels got=%0d bad want=0", pass_errors(0, n)); end
    endtask

    task automatic test_mid_reset();
        bit started = 1'b0;
        fork
            send_byte(8'h23, 1'b0);
            begin
                for (int t = 0; t < 400 && plot !== 1'b1; t++) @(negedge clk);
                started = (plot === 1'b1);
                repeat (100) @(negedge clk);
                key = 4'b1110;
            end
        join
        #1;
        checks++; if (!started) begin failures++; $display("FAIL mid_reset_redraw got=none want=started"); end
        checks++;
        if (plot !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_color !== 24'd0) begin
            failures++; $display("FAIL mid_reset_outputs got=%0b %0d %0d %h want=0 0 0 000000", plot, vga_x, vga_y, vga_color);
        end
        repeat (3) @(negedge clk);
        checks++; if (plot !== 1'b0 || vga_color !== 24'd0) begin failures++; $display("FAIL mid_reset_hold got=%0b %h want=0 000000", plot, vga_color); end
        pressed_m = 8'd0;
    endtask

    task automatic test_back_to_back();
        int n7 = 0, n1 = 0, e7 = 0;
        pressed_m[1] = 1'b1;
        fork
            send_byte(8'h1B, 1'b0);
            begin
                capture_pass(10, n7);
                e7 = pass_errors(7, n7);
                capture_pass(10, n1);
            end
        join
        checks++; if (n7 !== 1600) begin failures++; $display("FAIL b2b_key7_count got=%0d want=1600", n7); end
        checks++; if (e7 !== 0) begin failures++; $display("FAIL b2b_key7_pixels got=%0d bad want=0", e7); end
        checks++; if (n1 !== 1600) begin failures++; $display("FAIL b2b_key1_count got=%0d want=1600", n1); end
        checks++; if (pass_errors(1, n1) !== 0) begin failures++; $display("FAIL b2b_key1_pixels got=%0d bad want=0", pass_errors(1, n1)); end
    endtask

    task automatic test_random();
        int n, r, k;
        bit brk, mapped, change;
        logic [7:0] code;
        for (int it = 0; it < 8; it++) begin
            r   = int'($urandom_range(0, 9));
            brk = 1'($urandom_range(0, 1));
            mapped = (r < 8);
            k    = mapped ? r : 0;
            code = mapped ? codes[r] : other[r - 8];
            change = mapped && (pressed_m[k] != !brk);
            fork
                begin if (brk) send_byte(8'hF0, 1'b0); send_byte(code, 1'b0); end
                capture_pass(700, n);
            join
            if (change) begin
                pressed_m[k] = !brk;
                checks++; if (n !== 1600) begin failures++; $display("FAIL rand%0d_count code=%h got=%0d want=1600", it, code, n); end
                checks++; if (pass_errors(k, n) !== 0) begin failures++; $display("FAIL rand%0d_pixels code=%h got=%0d bad want=0", it, code, pass_errors(k, n)); end
            end else begin
                checks++; if (n !== 0) begin failures++; $display("FAIL rand%0d_quiet code=%h brk=%0b got=%0d want=0", it, code, brk, n); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full(1'b0, 8'h00, 0);
        test_press();
        test_release();
        test_discard();
        test_mid_reset();
        test_full(1'b1, 8'h42, 7);
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
